i2s_clkgen: RTL and testbench

Parametrised I2S/TDM clock and frame-timing generator for the audio output path, running on the audio master clock. It derives bclk, wclk/frame-sync and the stereo MPX select from clk. It supports four rates, a configurable slot width and slot count, and either I2S or DSP/TDM frame-sync format. Rate changes and stop requests take effect only on frame boundaries, so downstream serializers never see a truncated frame.

---
 rtl/i2s_clkgen.sv | 185 ++++++++++++++++++
 tb/tb_i2s_clkgen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - I2S/TDM bit clock, word clock and frame timing generator
//
// Derives the serial audio timing from the audio master clock. Rate changes and
// stop requests are deferred to frame boundaries so a frame is never truncated.
//
// Ports:
//   clk         audio master clock
//   reset       synchronous, active-high
//   aud_rate    bclk half-period select: 0->4, 1->2, 2->1, 3->8 clk cycles
//   enable      run request
//   mclk        clk passthrough
//   bclk        bit clock (registered)
//   wclk        I2S word clock (MODE 0) or one-bclk frame sync (MODE 1)
//   mpx_sel     free-running MPX select, toggles every 2^MPX_LOG2 clk cycles
//   frame_start one-clk pulse on the first bclk rise of each frame
//   slot_idx    slot currently on the bus
//   bit_idx     bit within the slot, 0 = MSB
//   rate_busy   a rate change is waiting for the next frame boundary
module i2s_clkgen #(
    parameter int SLOT_BITS = 16,
    parameter int SLOTS     = 2,
    parameter int MODE      = 0,
    parameter int MPX_LOG2  = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   aud_rate,
    input  logic                         enable,
    output logic                         mclk,
    output logic                         bclk,
    output logic                         wclk,
    output logic                         mpx_sel,
    output logic                         frame_start,
    output logic [$clog2(SLOTS)-1:0]     slot_idx,
    output logic [$clog2(SLOT_BITS)-1:0] bit_idx,
    output logic                         rate_busy
);

    localparam int SW = $clog2(SLOTS);
    localparam int BW = $clog2(SLOT_BITS);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        div;
    logic [2:0]        half_last;
    logic [1:0]        active_rate;
    logic [1:0]        pending_rate;
    logic [1:0]        rate_nxt;
    logic [MPX_LOG2:0] mpx_cnt;
    logic              running;
    logic              div_wrap;
    logic              bclk_rise;
    logic              bclk_fall;
    logic              frame_wrap;
    logic              boundary;
    logic [SW-1:0]     slot_nxt;
    logic [BW-1:0]     bit_nxt;
    logic              wclk_nxt;

    assign mclk    = clk;
    assign mpx_sel = mpx_cnt[MPX_LOG2];

    // Terminal count of the half-period divider for the rate in force.
    always_comb begin
        case (active_rate)
            2'd0:    half_last = 3'd3;
            2'd1:    half_last = 3'd1;
            2'd2:    half_last = 3'd0;
            default: half_last = 3'd7;
        endcase
    end

    assign running    = (state != ST_IDLE);
    assign div_wrap   = running && (div == half_last);
    assign bclk_rise  = div_wrap && !bclk;
    assign bclk_fall  = div_wrap && bclk;
    assign frame_wrap = (slot_idx == SLOT_LAST) && (bit_idx == BIT_LAST);
    assign boundary   = bclk_fall && frame_wrap;
    assign rate_nxt   = rate_busy ? pending_rate : active_rate;

    // Bus position after the next bclk fall.
    always_comb begin
        bit_nxt  = bit_idx + BW'(1);
        slot_nxt = slot_idx;
        if (bit_idx == BIT_LAST) begin
            bit_nxt  = '0;
            slot_nxt = (slot_idx == SLOT_LAST) ? '0 : slot_idx + SW'(1);
        end
    end

    // wclk is set for the upcoming position, so it leads the data by one bclk.
    always_comb begin
        wclk_nxt = wclk;
        if (MODE == 0) begin
            if (bit_nxt == BIT_LAST) begin
                wclk_nxt = (((int'(slot_nxt) + 1) % SLOTS) >= (SLOTS / 2));
            end
        end else begin
            wclk_nxt = (slot_nxt == SLOT_LAST) && (bit_nxt == BIT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enable) state_nxt = ST_RUN;
            ST_RUN:  if (!enable) state_nxt = ST_STOP;
            ST_STOP: begin
                if (enable) begin
                    state_nxt = ST_RUN;
                end else if (boundary) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div          <= '0;
            bclk         <= 1'b0;
            wclk         <= 1'b0;
            frame_start  <= 1'b0;
            slot_idx     <= '0;
            bit_idx      <= '0;
            active_rate  <= aud_rate;
            pending_rate <= '0;
            rate_busy    <= 1'b0;
            mpx_cnt      <= '0;
        end else begin
            mpx_cnt     <= mpx_cnt + 1'b1;
            frame_start <= 1'b0;
            if (state == ST_IDLE) begin
                div          <= '0;
                bclk         <= 1'b0;
                wclk         <= 1'b0;
                slot_idx     <= '0;
                bit_idx      <= '0;
                active_rate  <= aud_rate;
                pending_rate <= aud_rate;
                rate_busy    <= 1'b0;
            end else begin
                div <= div_wrap ? 3'd0 : div + 3'd1;
                if (div_wrap) begin
                    bclk <= ~bclk;
                end
                if (bclk_rise && (slot_idx == '0) && (bit_idx == '0)) begin
                    frame_start <= 1'b1;
                end
                if (bclk_fall) begin
                    slot_idx <= slot_nxt;
                    bit_idx  <= bit_nxt;
                    wclk     <= wclk_nxt;
                end
                // pending tracks aud_rate every cycle; rate_busy says whether
                // it differs from the rate that will be in force.
                pending_rate <= aud_rate;
                if (boundary) begin
                    active_rate <= rate_nxt;
                    rate_busy   <= (aud_rate != rate_nxt) && (state_nxt != ST_IDLE);
                end else begin
                    rate_busy   <= (aud_rate != active_rate);
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_clkgen.sv
// tb/tb_i2s_clkgen.sv - scoreboard bench for i2s_clkgen (I2S and TDM instances)
module tb_i2s_clkgen;

    localparam int SB0 = 16;
    localparam int S0  = 2;
    localparam int M0  = 0;
    localparam int L0  = 7;
    localparam int SB1 = 32;
    localparam int S1  = 8;
    localparam int M1  = 1;
    localparam int L1  = 4;

    typedef struct {
        int c;
        int bclk;
        int wclk;
        int slot;
        int bitn;
        int fs;
        int busy;
        int mpx;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en [2];
    logic [1:0] rate [2];

    logic mclk0, bclk0, wclk0, mpx0, fs0, busy0;
    logic [$clog2(S0)-1:0]  slot0;
    logic [$clog2(SB0)-1:0] bit0;
    logic mclk1, bclk1, wclk1, mpx1, fs1, busy1;
    logic [$clog2(S1)-1:0]  slot1;
    logic [$clog2(SB1)-1:0] bit1;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q0 [$];
    exp_t q1 [$];

    // Frame-level reference state per instance.
    int m_run [2];
    int m_e [2];
    int m_r [2];
    int m_prev_en [2];
    int m_prev_rate [2];
    int m_cnt [2];

    always #5 clk = ~clk;

    i2s_clkgen #(.SLOT_BITS(SB0), .SLOTS(S0), .MODE(M0), .MPX_LOG2(L0)) dut0 (
        .clk(clk), .reset(reset), .aud_rate(rate[0]), .enable(en[0]),
        .mclk(mclk0), .bclk(bclk0), .wclk(wclk0), .mpx_sel(mpx0),
        .frame_start(fs0), .slot_idx(slot0), .bit_idx(bit0), .rate_busy(busy0)
    );

    i2s_clkgen #(.SLOT_BITS(SB1), .SLOTS(S1), .MODE(M1), .MPX_LOG2(L1)) dut1 (
        .clk(clk), .reset(reset), .aud_rate(rate[1]), .enable(en[1]),
        .mclk(mclk1), .bclk(bclk1), .wclk(wclk1), .mpx_sel(mpx1),
        .frame_start(fs1), .slot_idx(slot1), .bit_idx(bit1), .rate_busy(busy1)
    );

    function automatic int hof(int r);
        case (r)
            0:       return 4;
            1:       return 2;
            2:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic int sb_of(int d);
        return (d == 0) ? SB0 : SB1;
    endfunction

    function automatic int s_of(int d);
        return (d == 0) ? S0 : S1;
    endfunction

    function automatic int frame_len(int d, int r);
        return 2 * hof(r) * sb_of(d) * s_of(d);
    endfunction

    function automatic int pos(int d);
        return ((cyc - m_e[d]) / (2 * hof(m_r[d]))) % (sb_of(d) * s_of(d));
    endfunction

    // A frame begins at its entry cycle; bclk rises H cycles later and every
    // 2H cycles one bus position elapses. A frame continues into the next one
    // unless enable was low both at the boundary and the cycle before; the
    // next frame uses the aud_rate seen in the cycle before the boundary.
    task automatic model_step(int d, logic e_in, logic [1:0] r_in);
        int fr;
        if (reset) begin
            m_run[d] = 0;
            m_cnt[d] = 0;
        end else begin
            m_cnt[d] = m_cnt[d] + 1;
            fr = frame_len(d, m_r[d]);
            if (m_run[d] == 0) begin
                if (e_in) begin
                    m_run[d] = 1;
                    m_e[d]   = cyc;
                    m_r[d]   = int'(r_in);
                end
            end else if (cyc == m_e[d] + fr) begin
                if (e_in || (m_prev_en[d] != 0)) begin
                    m_e[d] = cyc;
                    m_r[d] = m_prev_rate[d];
                end else begin
                    m_run[d] = 0;
                end
            end
        end
        m_prev_en[d]   = int'(e_in);
        m_prev_rate[d] = int'(r_in);
    endtask

    function automatic exp_t predict(int d, logic [1:0] r_in);
        exp_t x;
        int   t, h, n, p, sb, s, md;
        sb = sb_of(d);
        s  = s_of(d);
        md = (d == 0) ? M0 : M1;
        x.c   = cyc;
        x.mpx = (m_cnt[d] >> ((d == 0) ? L0 : L1)) & 1;
        x.bclk = 0; x.wclk = 0; x.slot = 0; x.bitn = 0; x.fs = 0; x.busy = 0;
        if (m_run[d] != 0) begin
            t = cyc - m_e[d];
            h = hof(m_r[d]);
            n = sb * s;
            p = (t / (2 * h)) % n;
            x.bclk = (t / h) % 2;
            x.slot = p / sb;
            x.bitn = p % sb;
            x.fs   = (t == h) ? 1 : 0;
            if (md == 0) x.wclk = ((((p + 1) % n) / sb) >= (s / 2)) ? 1 : 0;
            else         x.wclk = (p == n - 1) ? 1 : 0;
            x.busy = (int'(r_in) != m_r[d]) ? 1 : 0;
        end
        return x;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        model_step(0, en[0], rate[0]);
        model_step(1, en[1], rate[1]);
        q0.push_back(predict(0, rate[0]));
        q1.push_back(predict(1, rate[1]));
    end

    task automatic cmp(string nm, int d, logic [31:0] act, int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0d expected=%0d", nm, d, cyc, act, expv);
        end
    endtask

    task automatic check_dut(int d, logic b, logic w, logic [31:0] sl, logic [31:0] bi,
                             logic f, logic bz, logic mx, logic mc);
        exp_t x;
        int   empty;
        empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty dut%0d cyc=%0d", d, cyc);
        end else begin
            if (d == 0) x = q0.pop_front();
            else        x = q1.pop_front();
            cmp("bclk", d, 32'(b), x.bclk);
            cmp("wclk", d, 32'(w), x.wclk);
            cmp("slot_idx", d, sl, x.slot);
            cmp("bit_idx", d, bi, x.bitn);
            cmp("frame_start", d, 32'(f), x.fs);
            cmp("rate_busy", d, 32'(bz), x.busy);
            cmp("mpx_sel", d, 32'(mx), x.mpx);
            cmp("mclk", d, 32'(mc), 0);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            check_dut(0, bclk0, wclk0, 32'(slot0), 32'(bit0), fs0, busy0, mpx0, mclk0);
            check_dut(1, bclk1, wclk1, 32'(slot1), 32'(bit1), fs1, busy1, mpx1, mclk1);
        end
    end

    task automatic wait_cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge just before the boundary clock edge of instance d.
    task automatic wait_boundary(int d);
        int k;
        k = 0;
        while (!((m_run[d] != 0) && (m_e[d] + frame_len(d, m_r[d]) == cyc + 1)) && (k < 20000)) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 20000) begin
            failures++;
            $display("FAIL boundary_wait dut%0d timeout cyc=%0d", d, cyc);
        end
    endtask

    task automatic wait_pos(int d, int p);
        int k;
        k = 0;
        while (!((m_run[d] != 0) && (pos(d) == p)) && (k < 20000)) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 20000) begin
            failures++;
            $display("FAIL position_wait dut%0d timeout cyc=%0d", d, cyc);
        end
    endtask

    initial begin
        reset   = 1'b1;
        en[0]   = 1'b1;
        en[1]   = 1'b1;
        rate[0] = 2'd0;
        rate[1] = 2'd2;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(600);

        // 0 -> 2 mid-frame, takes effect at the next boundary
        wait_boundary(0);
        wait_cycles(100);
        rate[0] = 2'd2;
        wait_cycles(600);
        rate[0] = 2'd0;
        wait_cycles(200);

        // 0 -> 1 -> 0 inside one frame
        wait_boundary(0);
        wait_cycles(30);
        rate[0] = 2'd1;
        wait_cycles(20);
        rate[0] = 2'd0;
        wait_cycles(600);

        // stop at slot 1 bit 5, then restart
        wait_pos(0, SB0 + 5);
        en[0] = 1'b0;
        wait_cycles(400);
        en[0] = 1'b1;
        wait_cycles(400);

        // rate change and enable drop landing exactly on the boundary cycle
        wait_boundary(0);
        rate[0] = 2'd3;
        wait_cycles(1200);
        wait_boundary(0);
        en[0] = 1'b0;
        wait_cycles(1200);
        en[0] = 1'b1;
        wait_cycles(300);
        wait_boundary(1);
        rate[1] = 2'd0;
        en[1]   = 1'b0;
        wait_cycles(2000);
        en[1] = 1'b1;
        wait_cycles(200);

        // reset in mid-frame
        wait_cycles(137);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        wait_cycles(300);

        for (int i = 0; i < 40; i++) begin
            wait_cycles($urandom_range(1, 400));
            case ($urandom_range(0, 5))
                0: rate[0] = 2'($urandom_range(0, 3));
                1: en[0] = ~en[0];
                2: rate[1] = 2'($urandom_range(0, 3));
                3: en[1] = ~en[1];
                4: begin
                    reset = 1'b1;
                    wait_cycles(1);
                    reset = 1'b0;
                end
                default: begin
                    if (m_run[0] != 0) begin
                        wait_boundary(0);
                        rate[0] = 2'($urandom_range(0, 3));
                    end
                end
            endcase
        end
        en[0] = 1'b1;
        en[1] = 1'b1;
        wait_cycles(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
